// File: rtl/linear_fc_reader.sv
// FC weight-ROM read initiator: one sparse (idx, feature) beat per cycle, MAC into FC_OUT_C logits.
// Logits valid 2 cycles after the last beat; input stalls while logits wait on out_ready.
package aegnn_pkg;
    localparam int FC_W_WIDTH = 8;
endpackage

module linear_fc_reader
    import aegnn_pkg::*;
#(
    parameter  int FC_IN_C       = 1792,
    parameter  int FC_OUT_C      = 2,
    parameter  int FEAT_WIDTH    = 8,
    parameter  int ACC_WIDTH     = 32,
    localparam int FC_IN_C_WIDTH = $clog2(FC_IN_C)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            feat_valid,
    output logic                            feat_ready,
    input  logic [FC_IN_C_WIDTH-1:0]        feat_idx,
    input  logic [FEAT_WIDTH-1:0]           feat_data,
    input  logic                            feat_last,
    output logic                            rd_en,
    output logic [FC_IN_C_WIDTH-1:0]        w_idx,
    input  logic [FC_OUT_C*FC_W_WIDTH-1:0]  fc_w,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [FC_OUT_C*ACC_WIDTH-1:0]   out_logits,
    output logic                            idx_err
);
    localparam int PW = FEAT_WIDTH + FC_W_WIDTH;

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_DRAIN,
        ST_OUT
    } state_t;

    state_t                          state_q, state_d;
    logic                            s1_valid_q, s1_err_q;
    logic signed [FEAT_WIDTH-1:0]    s1_data_q;
    logic [FC_OUT_C*ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [ACC_WIDTH-1:0]            prod_ext [FC_OUT_C];
    logic                            accept, in_range;
    logic [31:0]                     idx_ext;

    assign idx_ext    = 32'(feat_idx);
    assign in_range   = idx_ext < 32'(FC_IN_C);
    assign feat_ready = (state_q == ST_ACCUM);
    assign accept     = feat_valid && feat_ready;
    assign rd_en      = accept && in_range;
    assign w_idx      = accept ? feat_idx : '0;
    assign out_valid  = (state_q == ST_OUT);
    assign out_logits = acc_q;
    assign idx_err    = s1_err_q;

    // Weight row arrives one cycle after the read, aligned with stage 1.
    for (genvar k = 0; k < FC_OUT_C; k++) begin : g_mac
        logic signed [FC_W_WIDTH-1:0] w_k;
        logic signed [PW-1:0]         p_k;
        assign w_k         = fc_w[k*FC_W_WIDTH +: FC_W_WIDTH];
        assign p_k         = PW'(s1_data_q) * PW'(w_k);
        assign prod_ext[k] = ACC_WIDTH'(p_k);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: if (accept && feat_last) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_OUT;
            ST_OUT:   if (out_ready) state_d = ST_ACCUM;
            default:  state_d = ST_ACCUM;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        if (state_q == ST_OUT && out_ready) begin
            acc_d = '0;
        end else if (s1_valid_q) begin
            for (int k = 0; k < FC_OUT_C; k++) begin
                acc_d[k*ACC_WIDTH +: ACC_WIDTH] = acc_q[k*ACC_WIDTH +: ACC_WIDTH] + prod_ext[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ACCUM;
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_data_q  <= '0;
            acc_q      <= '0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= accept;
            s1_err_q   <= accept && !in_range;
            s1_data_q  <= accept ? feat_data : '0;
            acc_q      <= acc_d;
        end
    end
endmodule

// File: tb/tb_linear_fc_reader.sv
// Directed bench: two instances share one input stream; A (8 rows, 32-bit acc), B (6 rows, 12-bit acc).
// B covers out-of-range indices and accumulator wrap.
module tb_linear_fc_reader;
    logic        clk, rst;
    logic        feat_valid, feat_last, out_ready;
    logic [2:0]  feat_idx;
    logic [7:0]  feat_data;
    logic        feat_ready_a, rd_en_a, out_valid_a, idx_err_a;
    logic        feat_ready_b, rd_en_b, out_valid_b, idx_err_b;
    logic [2:0]  w_idx_a, w_idx_b;
    logic [15:0] fc_w_a, fc_w_b;
    logic [63:0] out_logits_a;
    logic [23:0] out_logits_b;

    int total = 0;
    int bad   = 0;
    int rd_cnt_a = 0, rd_cnt_b = 0, err_cnt_a = 0, err_cnt_b = 0;
    logic [2:0] hist_a [256];
    logic [2:0] hist_b [256];

    linear_fc_reader #(.FC_IN_C(8), .FC_OUT_C(2), .FEAT_WIDTH(8), .ACC_WIDTH(32)) dut_a (
        .clk(clk), .rst(rst), .feat_valid(feat_valid), .feat_ready(feat_ready_a),
        .feat_idx(feat_idx), .feat_data(feat_data), .feat_last(feat_last),
        .rd_en(rd_en_a), .w_idx(w_idx_a), .fc_w(fc_w_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_logits(out_logits_a), .idx_err(idx_err_a));

    linear_fc_reader #(.FC_IN_C(6), .FC_OUT_C(2), .FEAT_WIDTH(8), .ACC_WIDTH(12)) dut_b (
        .clk(clk), .rst(rst), .feat_valid(feat_valid), .feat_ready(feat_ready_b),
        .feat_idx(feat_idx), .feat_data(feat_data), .feat_last(feat_last),
        .rd_en(rd_en_b), .w_idx(w_idx_b), .fc_w(fc_w_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_logits(out_logits_b), .idx_err(idx_err_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Weight ROM: row i = {ch1 = -(i+1), ch0 = i+1}, registered, zero when not read.
    function automatic logic [15:0] rom_row(input logic [2:0] i);
        logic [7:0] p;
        p = 8'(i) + 8'd1;
        return {8'd0 - p, p};
    endfunction

    always @(posedge clk) begin
        fc_w_a <= rd_en_a ? rom_row(w_idx_a) : 16'd0;
        fc_w_b <= rd_en_b ? rom_row(w_idx_b) : 16'd0;
    end

    always @(negedge clk) begin
        if (rd_en_a) begin hist_a[rd_cnt_a % 256] = w_idx_a; rd_cnt_a++; end
        if (rd_en_b) begin hist_b[rd_cnt_b % 256] = w_idx_b; rd_cnt_b++; end
        if (idx_err_a) err_cnt_a++;
        if (idx_err_b) err_cnt_b++;
    end

    function automatic int cha(input int k);
        logic signed [31:0] v;
        v = out_logits_a[k*32 +: 32];
        return int'(v);
    endfunction

    function automatic int chb(input int k);
        logic signed [11:0] v;
        v = out_logits_b[k*12 +: 12];
        return int'(v);
    endfunction

    task automatic beat(input logic [2:0] idx, input int d, input logic last);
        feat_valid = 1'b1; feat_idx = idx; feat_data = 8'(d); feat_last = last;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (feat_ready_a) break;
        end
        @(posedge clk); #1;
        feat_valid = 1'b0; feat_last = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (out_valid_a) break;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (rd_en_a !== 1'b0) begin bad++; $display("FAIL rst_rd_en got=%0b exp=0", rd_en_a); end
        total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid_a); end
        total++; if (idx_err_a !== 1'b0) begin bad++; $display("FAIL rst_idx_err got=%0b exp=0", idx_err_a); end
        total++; if (out_logits_a !== 64'd0) begin bad++; $display("FAIL rst_logits got=%0h exp=0", out_logits_a); end
        total++; if (w_idx_a !== 3'd0) begin bad++; $display("FAIL rst_w_idx got=%0d exp=0", w_idx_a); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (feat_ready_a !== 1'b1) begin bad++; $display("FAIL rst_feat_ready got=%0b exp=1", feat_ready_a); end
        total++; if (out_valid_b !== 1'b0) begin bad++; $display("FAIL rst_out_valid_b got=%0b exp=0", out_valid_b); end
    endtask

    task automatic test_two_beat();
        int r0, n;
        @(posedge clk); #1;
        r0 = rd_cnt_a;
        out_ready = 1'b1;
        beat(3'd0, 2, 1'b0);
        beat(3'd3, -1, 1'b1);
        wait_valid(n);
        total++; if (n != 2) begin bad++; $display("FAIL two_latency got=%0d exp=2", n); end
        total++; if (rd_cnt_a - r0 != 2) begin bad++; $display("FAIL two_rd_count got=%0d exp=2", rd_cnt_a - r0); end
        total++; if (hist_a[r0 % 256] !== 3'd0) begin bad++; $display("FAIL two_widx0 got=%0d exp=0", hist_a[r0 % 256]); end
        total++; if (hist_a[(r0 + 1) % 256] !== 3'd3) begin bad++; $display("FAIL two_widx1 got=%0d exp=3", hist_a[(r0 + 1) % 256]); end
        total++; if (cha(0) != -2) begin bad++; $display("FAIL two_ch0 got=%0d exp=-2", cha(0)); end
        total++; if (cha(1) != 2) begin bad++; $display("FAIL two_ch1 got=%0d exp=2", cha(1)); end
        total++; if (feat_ready_a !== 1'b0) begin bad++; $display("FAIL two_ready_out got=%0b exp=0", feat_ready_a); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        total++; if (feat_ready_a !== 1'b1) begin bad++; $display("FAIL two_ready_after got=%0b exp=1", feat_ready_a); end
        total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL two_valid_after got=%0b exp=0", out_valid_a); end
        total++; if (out_logits_a !== 64'd0) begin bad++; $display("FAIL two_cleared got=%0h exp=0", out_logits_a); end
    endtask

    task automatic test_backpressure();
        int r0, n;
        @(posedge clk); #1;
        beat(3'd0, 2, 1'b0);
        beat(3'd3, -1, 1'b1);
        wait_valid(n);
        total++; if (n != 2) begin bad++; $display("FAIL bp_latency got=%0d exp=2", n); end
        r0 = rd_cnt_a;
        feat_valid = 1'b1; feat_idx = 3'd5; feat_data = 8'd9; feat_last = 1'b1;
        repeat (10) begin
            @(negedge clk);
            total++; if (out_valid_a !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got=%0b exp=1", out_valid_a); end
            total++; if (feat_ready_a !== 1'b0) begin bad++; $display("FAIL bp_hold_ready got=%0b exp=0", feat_ready_a); end
            total++; if (cha(0) != -2 || cha(1) != 2) begin bad++; $display("FAIL bp_hold_logits got=%0d,%0d exp=-2,2", cha(0), cha(1)); end
        end
        total++; if (rd_cnt_a != r0) begin bad++; $display("FAIL bp_no_read got=%0d exp=%0d", rd_cnt_a, r0); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; feat_valid = 1'b0; feat_last = 1'b0;
        beat(3'd7, 1, 1'b1);
        wait_valid(n);
        total++; if (cha(0) != 8) begin bad++; $display("FAIL bp_next_ch0 got=%0d exp=8", cha(0)); end
        total++; if (cha(1) != -8) begin bad++; $display("FAIL bp_next_ch1 got=%0d exp=-8", cha(1)); end
        consume();
    endtask

    task automatic test_out_of_range();
        int rb, eb, ea, ra, n;
        @(posedge clk); #1;
        rb = rd_cnt_b; eb = err_cnt_b; ea = err_cnt_a; ra = rd_cnt_a;
        beat(3'd7, 5, 1'b0);
        beat(3'd1, 3, 1'b1);
        wait_valid(n);
        total++; if (err_cnt_b - eb != 1) begin bad++; $display("FAIL oor_idx_err got=%0d exp=1", err_cnt_b - eb); end
        total++; if (rd_cnt_b - rb != 1) begin bad++; $display("FAIL oor_rd_count got=%0d exp=1", rd_cnt_b - rb); end
        total++; if (hist_b[rb % 256] !== 3'd1) begin bad++; $display("FAIL oor_widx got=%0d exp=1", hist_b[rb % 256]); end
        total++; if (chb(0) != 6) begin bad++; $display("FAIL oor_ch0 got=%0d exp=6", chb(0)); end
        total++; if (chb(1) != -6) begin bad++; $display("FAIL oor_ch1 got=%0d exp=-6", chb(1)); end
        total++; if (err_cnt_a - ea != 0) begin bad++; $display("FAIL oor_a_no_err got=%0d exp=0", err_cnt_a - ea); end
        total++; if (rd_cnt_a - ra != 2) begin bad++; $display("FAIL oor_a_rd got=%0d exp=2", rd_cnt_a - ra); end
        consume();
    endtask

    task automatic test_extremes();
        int n;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) beat(3'(i), -128, (i == 7));
        wait_valid(n);
        total++; if (cha(0) != -4608) begin bad++; $display("FAIL ext_ch0 got=%0d exp=-4608", cha(0)); end
        total++; if (cha(1) != 4608) begin bad++; $display("FAIL ext_ch1 got=%0d exp=4608", cha(1)); end
        consume();
    endtask

    task automatic test_wrap();
        int n;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) beat(3'd5, -128, (i == 2));
        wait_valid(n);
        // -2304 and +2304 do not fit 12 bits; they wrap by 4096.
        total++; if (chb(0) != 1792) begin bad++; $display("FAIL wrap_ch0 got=%0d exp=1792", chb(0)); end
        total++; if (chb(1) != -1792) begin bad++; $display("FAIL wrap_ch1 got=%0d exp=-1792", chb(1)); end
        total++; if (cha(0) != -2304) begin bad++; $display("FAIL wrap_a_ch0 got=%0d exp=-2304", cha(0)); end
        consume();
    endtask

    task automatic test_gapped();
        int r0, n, gaps;
        @(posedge clk); #1;
        r0 = rd_cnt_a;
        beat(3'd2, 1, 1'b0);
        @(negedge clk);
        gaps = $urandom_range(1, 3);
        repeat (gaps) begin
            @(negedge clk);
            total++; if (cha(0) != 3 || out_valid_a !== 1'b0) begin bad++; $display("FAIL gap_idle got=%0d/%0b exp=3/0", cha(0), out_valid_a); end
        end
        @(posedge clk); #1;
        beat(3'd2, 1, 1'b1);
        wait_valid(n);
        total++; if (n != 2) begin bad++; $display("FAIL gap_latency got=%0d exp=2", n); end
        total++; if (rd_cnt_a - r0 != 2) begin bad++; $display("FAIL gap_rd_count got=%0d exp=2", rd_cnt_a - r0); end
        total++; if (cha(0) != 6) begin bad++; $display("FAIL gap_ch0 got=%0d exp=6", cha(0)); end
        total++; if (cha(1) != -6) begin bad++; $display("FAIL gap_ch1 got=%0d exp=-6", cha(1)); end
        consume();
    endtask

    task automatic test_reset_mid();
        int n;
        @(posedge clk); #1;
        beat(3'd5, 7, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        total++; if (rd_en_a !== 1'b0 || out_valid_a !== 1'b0 || idx_err_a !== 1'b0) begin bad++; $display("FAIL mid_rst_ctrl got=%0b%0b%0b exp=000", rd_en_a, out_valid_a, idx_err_a); end
        total++; if (out_logits_a !== 64'd0) begin bad++; $display("FAIL mid_rst_logits got=%0h exp=0", out_logits_a); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (out_logits_a !== 64'd0 || out_valid_a !== 1'b0) begin bad++; $display("FAIL mid_after_rst got=%0h/%0b exp=0/0", out_logits_a, out_valid_a); end
        total++; if (feat_ready_a !== 1'b1) begin bad++; $display("FAIL mid_after_ready got=%0b exp=1", feat_ready_a); end
        @(posedge clk); #1;
        beat(3'd4, 1, 1'b1);
        wait_valid(n);
        total++; if (cha(0) != 5) begin bad++; $display("FAIL mid_ch0 got=%0d exp=5", cha(0)); end
        total++; if (cha(1) != -5) begin bad++; $display("FAIL mid_ch1 got=%0d exp=-5", cha(1)); end
        consume();
    endtask

    initial begin
        rst = 1'b1; feat_valid = 1'b0; feat_idx = 3'd0; feat_data = 8'd0;
        feat_last = 1'b0; out_ready = 1'b0;
        test_reset();
        test_two_beat();
        test_backpressure();
        test_out_of_range();
        test_extremes();
        test_wrap();
        test_gapped();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
